// File: rtl/decode_ctrl_pipe.sv
// D-stage decode with D/E control register, load-use and mult/div busy stalls.
// Branch/jump outputs are combinational; E controls land one edge later; a stall or flush loads a bubble.
module decode_ctrl_pipe #(
  parameter int ALUOP_W     = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr_d,
  input  logic               flush_e,
  output logic               stall_d,
  output logic               branch_d,
  output logic               bne_d,
  output logic               jump_d,
  output logic               jr_d,
  output logic               reg_write_e,
  output logic               mem_write_e,
  output logic [1:0]         mem_to_reg_e,
  output logic               alu_src_e,
  output logic [ALUOP_W-1:0] alu_op_e,
  output logic               ext_op_e,
  output logic [4:0]         dst_e,
  output logic [1:0]         md_op_e,
  output logic               hilo_sel_e,
  output logic               md_busy
);

  typedef struct packed {
    logic               reg_write;
    logic               mem_write;
    logic [1:0]         mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               ext_op;
    logic [4:0]         dst;
    logic [1:0]         md_op;
    logic               hilo_sel;
  } ctrl_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(7);

  logic [5:0]       w_op;
  logic [5:0]       w_funct;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic [4:0]       w_rd;
  logic [4:0]       w_dst_raw;
  logic             w_rs_rd;
  logic             w_rt_rd;
  logic             w_md_d;
  logic             w_load_use;
  logic             w_md_stall;
  logic             w_unused;
  ctrl_t            w_dec;
  ctrl_t            r_e;
  logic [CNT_W-1:0] r_cnt;

  assign w_op     = instr_d[31:26];
  assign w_rs     = instr_d[25:21];
  assign w_rt     = instr_d[20:16];
  assign w_rd     = instr_d[15:11];
  assign w_funct  = instr_d[5:0];
  assign w_unused = ^instr_d[10:6];

  always_comb begin
    w_dec     = '0;
    w_dst_raw = 5'd0;
    w_rs_rd   = 1'b0;
    w_rt_rd   = 1'b0;
    w_md_d    = 1'b0;
    branch_d  = 1'b0;
    bne_d     = 1'b0;
    jump_d    = 1'b0;
    jr_d      = 1'b0;
    case (w_op)
      6'h00: begin
        // the all-zero word is sll $0,$0,0 but must stay a pure bubble
        if (instr_d != 32'd0) begin
          case (w_funct)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
              w_dec.reg_write = 1'b1;
              w_dst_raw       = w_rd;
              w_rs_rd         = 1'b1;
              w_rt_rd         = 1'b1;
              case (w_funct)
                6'h22, 6'h23: w_dec.alu_op = ALU_SUB;
                6'h24:        w_dec.alu_op = ALU_AND;
                6'h25:        w_dec.alu_op = ALU_OR;
                6'h26:        w_dec.alu_op = ALU_XOR;
                default:      w_dec.alu_op = ALU_ADD;
              endcase
            end
            6'h00, 6'h02: begin
              w_dec.reg_write = 1'b1;
              w_dst_raw       = w_rd;
              w_rt_rd         = 1'b1;
              w_dec.alu_op    = (w_funct == 6'h00) ? ALU_SLL : ALU_SRL;
            end
            6'h08: begin
              jr_d    = 1'b1;
              w_rs_rd = 1'b1;
            end
            6'h18, 6'h19, 6'h1A, 6'h1B: begin
              w_md_d      = 1'b1;
              w_rs_rd     = 1'b1;
              w_rt_rd     = 1'b1;
              w_dec.md_op = w_funct[1] ? 2'b10 : 2'b01;
            end
            6'h10, 6'h12: begin
              w_md_d           = 1'b1;
              w_dec.reg_write  = 1'b1;
              w_dec.mem_to_reg = 2'b11;
              w_dec.md_op      = 2'b11;
              w_dec.hilo_sel   = (w_funct == 6'h10);
              w_dst_raw        = w_rd;
            end
            default: ;
          endcase
        end
      end
      6'h08, 6'h09: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dst_raw       = w_rt;
        w_rs_rd         = 1'b1;
      end
      6'h23: begin
        w_dec.reg_write  = 1'b1;
        w_dec.mem_to_reg = 2'b01;
        w_dec.alu_src    = 1'b1;
        w_dst_raw        = w_rt;
        w_rs_rd          = 1'b1;
      end
      6'h2B: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_rs_rd         = 1'b1;
        w_rt_rd         = 1'b1;
      end
      6'h0F: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = ALU_LUI;
        w_dst_raw       = w_rt;
      end
      6'h0D: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_op    = ALU_OR;
        w_dec.ext_op    = 1'b1;
        w_dst_raw       = w_rt;
        w_rs_rd         = 1'b1;
      end
      6'h04, 6'h05: begin
        branch_d = 1'b1;
        bne_d    = w_op[0];
        w_rs_rd  = 1'b1;
        w_rt_rd  = 1'b1;
      end
      6'h02: jump_d = 1'b1;
      6'h03: begin
        jump_d           = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.mem_to_reg = 2'b10;
        w_dst_raw        = 5'd31;
      end
      default: ;
    endcase
    w_dec.dst = (w_dec.reg_write && w_dst_raw != 5'd0) ? w_dst_raw : 5'd0;
  end

  assign md_busy    = (r_cnt != '0);
  assign w_load_use = (r_e.mem_to_reg == 2'b01) && r_e.reg_write && (r_e.dst != 5'd0) &&
                      ((w_rs_rd && w_rs == r_e.dst) || (w_rt_rd && w_rt == r_e.dst));
  assign w_md_stall = w_md_d && (md_busy || r_e.md_op == 2'b01 || r_e.md_op == 2'b10);
  assign stall_d    = w_load_use || w_md_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
    end else if (flush_e || stall_d) begin
      r_e <= '0;
    end else begin
      r_e <= w_dec;
    end
  end

  // counting starts as the op leaves E, so busy covers the cycles after its E cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_e.md_op == 2'b01) begin
      r_cnt <= CNT_W'(MULT_CYCLES);
    end else if (r_e.md_op == 2'b10) begin
      r_cnt <= CNT_W'(DIV_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign reg_write_e  = r_e.reg_write;
  assign mem_write_e  = r_e.mem_write;
  assign mem_to_reg_e = r_e.mem_to_reg;
  assign alu_src_e    = r_e.alu_src;
  assign alu_op_e     = r_e.alu_op;
  assign ext_op_e     = r_e.ext_op;
  assign dst_e        = r_e.dst;
  assign md_op_e      = r_e.md_op;
  assign hilo_sel_e   = r_e.hilo_sel;

endmodule
